b01_word_collector: RTL and testbench
=====================================

// Module: b01_word_collector
// PURPOSE
//  Downstream stage of the b01 serial comparator FSM. Samples its serial outputs (outp -> bit_in,
//  overflw -> ovf_in) on qualified cycles, packs them MSB-first into WORD_W-bit words, and tags
//  each word with an overflow flag. Words are handed to a consumer through a 2-entry
//  first-word-fall-through buffer with valid/ready handshake.
// PARAMETERS
//  WORD_W  8  bits per assembled word (>=2)
//  CNT_W   8  width of saturating overflow-event counter
// PORTS
//  clock        in   1       rising-edge clock
//  reset        in   1       asynchronous, active-high reset
//  bit_in       in   1       serial data bit (b01 outp)
//  ovf_in       in   1       serial overflow flag (b01 overflw)
//  bit_en       in   1       bit_in/ovf_in valid this cycle
//  frame_start  in   1       with bit_en: this bit is bit 0 of a new word
//  out_ready    in   1       consumer accepts word this cycle
//  word_out     out  WORD_W  head word; first sampled bit in MSB
//  word_ovf     out  1       head word saw ovf_in=1 on any of its bits
//  word_valid   out  1       buffer non-empty
//  ovf_count    out  CNT_W   saturating count of bit_en&ovf_in cycles
//  drop_err     out  1       sticky: completed word discarded, buffer full
//  busy         out  1       FSM in COLLECT
// BEHAVIOUR
//  Reset (async, immediate): FSM=IDLE, bit_cnt=0, shreg=0, acc_ovf=0, buffer empty; word_out=0,
//   word_ovf=0, word_valid=0, ovf_count=0, drop_err=0, busy=0. Reset mid-word discards partial
//   word and buffered words.
//  FSM IDLE: bit_en&frame_start -> COLLECT; sample taken as bit 0 (bit_cnt<=1). Other bits ignored.
//  FSM COLLECT: each bit_en: shreg<={shreg[WORD_W-2:0],bit_in}; acc_ovf|=ovf_in; bit_cnt++.
//   No bit_en: hold everything.
//  Word complete: bit_en with bit_cnt==WORD_W-1 -> push {shreg,bit_in},acc_ovf|ovf_in; bit_cnt<=0,
//   acc_ovf<=0; stay COLLECT (continuous framing, next bit_en is bit 0 of next word).
//  Resync: bit_en&frame_start in COLLECT with bit_cnt!=0 -> partial word discarded, no push, bit
//   taken as bit 0 (bit_cnt<=1, acc_ovf<=ovf_in). frame_start at bit_cnt==0 is a normal bit 0.
//  frame_start without bit_en: ignored in all states.
//  Latency: word_valid rises the cycle after the edge sampling the final bit (1 clock).
//  Handshake: pop when word_valid&out_ready. word_out/word_ovf stable while word_valid&!out_ready.
//   out_ready while empty has no effect.
//  Full (2 words): push with simultaneous pop succeeds; push without pop drops the new word, sets
//   drop_err (cleared only by reset), buffer content unchanged. Push when empty + out_ready same
//   cycle: no bypass; word appears next cycle.
//  ovf_count: +1 per bit_en&ovf_in cycle in any state (incl. IDLE); saturates at 2^CNT_W-1, no wrap.
//  Outputs registered; no combinational path from inputs to word_out/word_valid.
// STRUCTURE
//  b01_pkg: FSM state encoding (IDLE=0, COLLECT=1), default WORD_W/CNT_W constants.
//  Sub-module word_fifo2: 2-entry FWFT buffer, data WORD_W+1, push/pop/full/empty/valid.
//  Top: FSM, shift register, bit counter, ovf accumulator, saturating counter, drop_err.
// TESTING
//  1 reset: check all outputs 0; frame_start w/o bit_en -> stays IDLE, busy=0.
//  2 frame_start+8 bit_en bits 1,0,1,1,0,0,1,0, ovf_in=0 -> word_out=8'hB2, word_ovf=0, valid 1 clk later.
//  3 same, ovf_in=1 only on bit 5 -> word_ovf=1, ovf_count=1; next word w/o ovf -> word_ovf=0.
//  4 out_ready=0, 3 words sent -> 2 held in order, 3rd dropped, drop_err=1; pop+push when full -> no drop.
//  5 frame_start after 5 bits, then 8 bits 8'h5A -> only 8'h5A emitted; reset mid-word -> nothing emitted.
//  6 CNT_W=4, 20 bit_en&ovf_in cycles -> ovf_count saturates at 15.

Source files
------------

// File: rtl/b01_pkg.sv
// Shared definitions for the b01 word collector: FSM encoding and default widths.
package b01_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  localparam int WORD_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

endpackage

// File: rtl/b01_word_fifo2.sv
// Two-entry first-word-fall-through buffer; head entry is a flop so dout is registered.
module word_fifo2 #(
  parameter int DW = 9
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          valid
);

  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          pop_ok, push_ok;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    pop_ok  = pop && (cnt_q != 2'd0);
    // A push into a full buffer is accepted only when the head leaves on the same edge.
    push_ok = push && ((cnt_q != 2'd2) || pop_ok);
    case ({push_ok, pop_ok})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = din;
        else               tail_d = din;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = din;
        end else begin
          head_d = tail_q;
          tail_d = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout  = head_q;
  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign valid = (cnt_q != 2'd0);

endmodule

// File: rtl/b01_word_collector.sv
// Packs the b01 serial outputs MSB-first into words tagged with an overflow flag,
// and hands them to a consumer through a 2-entry valid/ready buffer.
module b01_word_collector
  import b01_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bit_in,
  input  logic              ovf_in,
  input  logic              bit_en,
  input  logic              frame_start,
  input  logic              out_ready,
  output logic [WORD_W-1:0] word_out,
  output logic              word_ovf,
  output logic              word_valid,
  output logic [CNT_W-1:0]  ovf_count,
  output logic              drop_err,
  output logic              busy
);

  localparam int                BC_W = $clog2(WORD_W);
  localparam logic [BC_W-1:0]   LAST = BC_W'(WORD_W - 1);

  state_e            state_q, state_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              acc_ovf_q, acc_ovf_d;
  logic [CNT_W-1:0]  ovf_count_q, ovf_count_d;
  logic              drop_err_q, drop_err_d;
  logic              busy_q, busy_d;

  logic              push, pop;
  logic [WORD_W:0]   push_data, fifo_dout;
  logic              fifo_full, fifo_empty, fifo_valid;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    acc_ovf_d = acc_ovf_q;
    push      = 1'b0;
    push_data = {acc_ovf_q | ovf_in, shreg_q[WORD_W-2:0], bit_in};
    if (bit_en) begin
      // frame_start restarts a word from IDLE or mid-word; at bit 0 it is just a normal bit.
      if ((state_q == IDLE && frame_start) ||
          (state_q == COLLECT && frame_start && bit_cnt_q != '0)) begin
        state_d   = COLLECT;
        shreg_d   = {{(WORD_W-1){1'b0}}, bit_in};
        bit_cnt_d = BC_W'(1);
        acc_ovf_d = ovf_in;
      end else if (state_q == COLLECT) begin
        shreg_d = {shreg_q[WORD_W-2:0], bit_in};
        if (bit_cnt_q == LAST) begin
          push      = 1'b1;
          bit_cnt_d = '0;
          acc_ovf_d = 1'b0;
        end else begin
          bit_cnt_d = bit_cnt_q + BC_W'(1);
          acc_ovf_d = acc_ovf_q | ovf_in;
        end
      end
    end
  end

  always_comb begin
    pop         = out_ready && !fifo_empty;
    ovf_count_d = ovf_count_q;
    if (bit_en && ovf_in && (ovf_count_q != '1)) ovf_count_d = ovf_count_q + CNT_W'(1);
    drop_err_d  = drop_err_q | (push & fifo_full & ~pop);
    busy_d      = (state_d == COLLECT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      acc_ovf_q   <= 1'b0;
      ovf_count_q <= '0;
      drop_err_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      acc_ovf_q   <= acc_ovf_d;
      ovf_count_q <= ovf_count_d;
      drop_err_q  <= drop_err_d;
      busy_q      <= busy_d;
    end
  end

  word_fifo2 #(.DW(WORD_W + 1)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .valid (fifo_valid)
  );

  assign word_out   = fifo_dout[WORD_W-1:0];
  assign word_ovf   = fifo_dout[WORD_W];
  assign word_valid = fifo_valid;
  assign ovf_count  = ovf_count_q;
  assign drop_err   = drop_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_b01_word_collector.sv
// Scoreboard bench: bit-list reference model feeds an expected-word queue; a negedge monitor checks.
module tb_b01_word_collector;
  localparam int W = 8;

  logic clock = 1'b0, reset = 1'b1;
  logic bit_in = 1'b0, ovf_in = 1'b0, bit_en = 1'b0, frame_start = 1'b0, out_ready = 1'b0;
  logic [W-1:0] word_out, word_out4;
  logic         word_ovf, word_valid, drop_err, busy;
  logic         word_ovf4, word_valid4, drop_err4, busy4;
  logic [7:0]   ovf_count;
  logic [3:0]   ovf_count4;

  b01_word_collector #(.WORD_W(W), .CNT_W(8)) u_dut (
    .clock(clock), .reset(reset), .bit_in(bit_in), .ovf_in(ovf_in), .bit_en(bit_en),
    .frame_start(frame_start), .out_ready(out_ready), .word_out(word_out), .word_ovf(word_ovf),
    .word_valid(word_valid), .ovf_count(ovf_count), .drop_err(drop_err), .busy(busy));

  b01_word_collector #(.WORD_W(W), .CNT_W(4)) u_dut4 (
    .clock(clock), .reset(reset), .bit_in(bit_in), .ovf_in(ovf_in), .bit_en(bit_en),
    .frame_start(frame_start), .out_ready(out_ready), .word_out(word_out4), .word_ovf(word_ovf4),
    .word_valid(word_valid4), .ovf_count(ovf_count4), .drop_err(drop_err4), .busy(busy4));

  always #5 clock = ~clock;

  int n_cmp = 0, n_err = 0;

  // Reference model state
  logic [W:0] exp_q[$];
  bit         cur[$];
  bit         cur_ovf, mdl_active, mdl_drop;
  int         mdl_occ, mdl_cnt8, mdl_cnt4;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mdl_clear();
    exp_q.delete(); cur.delete();
    cur_ovf = 0; mdl_active = 0; mdl_drop = 0;
    mdl_occ = 0; mdl_cnt8 = 0; mdl_cnt4 = 0;
  endtask

  // Drive one cycle of inputs, then advance the model across the same edge.
  task automatic step(input bit b, input bit o, input bit en, input bit fs, input bit rdy);
    bit pop, done;
    logic [W:0] wd;
    bit_in = b; ovf_in = o; bit_en = en; frame_start = fs; out_ready = rdy;
    pop = (mdl_occ != 0) && rdy;
    done = 0; wd = '0;
    @(posedge clock);
    if (en) begin
      if (o) begin
        if (mdl_cnt8 < 255) mdl_cnt8++;
        if (mdl_cnt4 < 15)  mdl_cnt4++;
      end
      if (!mdl_active) begin
        if (fs) begin mdl_active = 1; cur.delete(); cur.push_back(b); cur_ovf = o; end
      end else if (fs && cur.size() != 0) begin
        cur.delete(); cur.push_back(b); cur_ovf = o;
      end else begin
        cur.push_back(b); cur_ovf |= o;
        if (cur.size() == W) begin
          done = 1; wd[W] = cur_ovf;
          for (int i = 0; i < W; i++) wd[W-1-i] = cur[i];
          cur.delete(); cur_ovf = 0;
        end
      end
    end
    if (pop) mdl_occ--;
    if (done) begin
      if (mdl_occ < 2) begin mdl_occ++; exp_q.push_back(wd); end
      else mdl_drop = 1;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1; bit_en = 0; frame_start = 0; out_ready = 0; bit_in = 0; ovf_in = 0;
    #1;
    chk("rst_word_out", word_out, 0);
    chk("rst_word_ovf", word_ovf, 0);
    chk("rst_word_valid", word_valid, 0);
    chk("rst_ovf_count", ovf_count, 0);
    chk("rst_drop_err", drop_err, 0);
    chk("rst_busy", busy, 0);
    mdl_clear();
    #1;
    reset = 0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic [W-1:0] om, input bit rdy_last);
    for (int i = 0; i < W; i++)
      step(w[W-1-i], om[W-1-i], 1, i == 0, (i == W-1) ? rdy_last : 1'b0);
  endtask

  task automatic drain();
    repeat (5) step(0, 0, 0, 0, 1);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      chk("word_valid", word_valid, mdl_occ != 0);
      chk("word_valid4", word_valid4, mdl_occ != 0);
      chk("busy", busy, mdl_active);
      chk("busy4", busy4, mdl_active);
      chk("drop_err", drop_err, mdl_drop);
      chk("drop_err4", drop_err4, mdl_drop);
      chk("ovf_count", ovf_count, mdl_cnt8);
      chk("ovf_count4", ovf_count4, mdl_cnt4);
      if (word_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL scoreboard: word %0h presented, none expected", {word_ovf, word_out});
        end else begin
          chk("word", {word_ovf, word_out}, exp_q[0]);
          chk("word4", {word_ovf4, word_out4}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [W-1:0] v;
    mdl_clear();
    #1;
    do_reset();

    // frame_start without bit_en stays idle
    step(1, 0, 0, 1, 0);
    chk("t1_busy", busy, 0);

    // basic word and latency
    v = 8'hB2;
    for (int i = 0; i < W; i++) begin
      step(v[W-1-i], 0, 1, i == 0, 0);
      if (i == W-2) chk("t2_not_yet", word_valid, 0);
    end
    chk("t2_latency", word_valid, 1);
    chk("t2_word", word_out, 8'hB2);
    chk("t2_ovf", word_ovf, 0);
    drain();

    // overflow tagging
    send_word(8'hB2, 8'b0000_0100, 0);
    chk("t3_ovf", word_ovf, 1);
    chk("t3_cnt", ovf_count, 1);
    drain();
    send_word(8'h3C, 8'h00, 0);
    chk("t3_ovf_clr", word_ovf, 0);
    drain();

    // full buffer: pop+push no drop, then drop
    do_reset();
    send_word(8'h11, 8'h00, 0);
    send_word(8'h22, 8'h80, 0);
    send_word(8'h33, 8'h00, 1);
    chk("t4_nodrop", drop_err, 0);
    send_word(8'h44, 8'h00, 0);
    chk("t4_drop", drop_err, 1);
    chk("t4_head", word_out, 8'h22);
    drain();

    // resync and reset mid-word
    do_reset();
    v = 8'hE7;
    for (int i = 0; i < 5; i++) step(v[W-1-i], 0, 1, i == 0, 0);
    send_word(8'h5A, 8'h00, 0);
    chk("t5_word", word_out, 8'h5A);
    drain();
    for (int i = 0; i < 4; i++) step(1, 0, 1, i == 0, 1);
    do_reset();
    repeat (12) step(0, 0, 0, 0, 1);
    chk("t5_reset_empty", word_valid, 0);

    // counter saturation
    do_reset();
    repeat (20) step(0, 1, 1, 0, 0);
    chk("t6_cnt4", ovf_count4, 15);
    chk("t6_cnt8", ovf_count, 20);

    // random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      step($urandom_range(0, 1), $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
    end
    drain();
    chk("end_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
